// File: rtl/axi_dac_jesd204_upack.sv
// axi_dac_jesd204_upack
//   Unpacks one packed DMA word (only enabled channels, time-major,
//   channel-interleaved) over L = NUM_CHANNELS/E dac_clk cycles so that each
//   enabled channel gets DATA_PATH_WIDTH samples per cycle.
// Ports:
//   dac_clk, dac_rst      clock, synchronous active-high reset
//   dac_enable            per-channel DMA select
//   s_dma_valid/ready     DMA word handshake (ready never depends on valid)
//   s_dma_data            packed word, slot k at [k*SW +: SW]
//   dac_data              channel c at [c*CW +: CW], sample j at [c*CW + j*SW +: SW]
//   dac_valid, dac_dunf   real samples / underflow flags, registered with dac_data

// Per-channel sample selector: picks the DATA_PATH_WIDTH slots that belong to
// this channel for the current sub-word.
module axi_dac_jesd204_upack_lane #(
  parameter int DPW = 4,
  parameter int SW  = 16,
  parameter int TW  = 128,
  parameter int IW  = 1,
  localparam int CW = DPW * SW
) (
  input  logic [TW-1:0] word,
  input  logic [IW-1:0] idx,
  input  logic [1:0]    log2e,
  input  logic [3:0]    rank,
  input  logic          en,
  output logic [CW-1:0] samples
);
  logic [31:0] slot;

  always_comb begin
    samples = '0;
    slot    = '0;
    if (en) begin
      for (int j = 0; j < DPW; j++) begin
        // slot = (idx*DPW + j)*E + rank, with E a power of two
        slot = ((32'(idx) * 32'(DPW) + 32'(j)) << log2e) + 32'(rank);
        samples[j*SW +: SW] = SW'(word >> (slot * 32'(SW)));
      end
    end
  end
endmodule

module axi_dac_jesd204_upack #(
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int OCT_PER_SAMPLE  = 2,
  localparam int SW = 8 * OCT_PER_SAMPLE,
  localparam int CW = DATA_PATH_WIDTH * SW,
  localparam int TW = NUM_CHANNELS * CW,
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    dac_clk,
  input  logic                    dac_rst,
  input  logic [NUM_CHANNELS-1:0] dac_enable,
  input  logic                    s_dma_valid,
  output logic                    s_dma_ready,
  input  logic [TW-1:0]           s_dma_data,
  output logic [TW-1:0]           dac_data,
  output logic                    dac_valid,
  output logic                    dac_dunf
);
  logic [TW-1:0]                   word_buf;
  logic                            buf_valid;
  logic [IW-1:0]                   idx;
  logic [NUM_CHANNELS-1:0]         enable_d;

  logic [3:0]                      num_en;
  logic [NUM_CHANNELS-1:0][3:0]    rank;
  logic [1:0]                      log2e;
  logic                            active;
  logic                            enable_change;
  logic [IW-1:0]                   last_idx;
  logic                            accept;
  logic [NUM_CHANNELS-1:0][CW-1:0] lane_data;

  // Running popcount gives each channel its rank among enabled channels.
  always_comb begin
    num_en = '0;
    rank   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rank[c] = num_en;
      num_en  = num_en + 4'(dac_enable[c]);
    end
  end

  // Only power-of-two enable counts pack evenly into a word.
  always_comb begin
    active = 1'b1;
    log2e  = 2'd0;
    case (num_en)
      4'd1:    log2e = 2'd0;
      4'd2:    log2e = 2'd1;
      4'd4:    log2e = 2'd2;
      4'd8:    log2e = 2'd3;
      default: active = 1'b0;
    endcase
  end

  assign last_idx      = IW'((32'(NUM_CHANNELS) >> log2e) - 32'd1);
  assign enable_change = (dac_enable != enable_d);
  assign s_dma_ready   = !dac_rst && active && !enable_change &&
                         (!buf_valid || (idx == last_idx));
  assign accept        = s_dma_valid && s_dma_ready;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
    axi_dac_jesd204_upack_lane #(
      .DPW (DATA_PATH_WIDTH),
      .SW  (SW),
      .TW  (TW),
      .IW  (IW)
    ) u_lane (
      .word    (word_buf),
      .idx     (idx),
      .log2e   (log2e),
      .rank    (rank[gi]),
      .en      (dac_enable[gi]),
      .samples (lane_data[gi])
    );
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      word_buf  <= '0;
      buf_valid <= 1'b0;
      idx       <= '0;
      enable_d  <= '0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      dac_dunf  <= 1'b0;
    end else begin
      enable_d <= dac_enable;
      if (!active || enable_change) begin
        // Idle or reconfiguring: drop whatever is buffered.
        buf_valid <= 1'b0;
        idx       <= '0;
        dac_data  <= '0;
        dac_valid <= 1'b0;
        dac_dunf  <= 1'b0;
      end else begin
        if (buf_valid) begin
          dac_data  <= lane_data;
          dac_valid <= 1'b1;
          dac_dunf  <= 1'b0;
          // idx parks at L-1 once drained; only accept/flush rewinds it.
          if (idx == last_idx) buf_valid <= 1'b0;
          else                 idx       <= idx + 1'b1;
        end else begin
          dac_data  <= '0;
          dac_valid <= 1'b0;
          dac_dunf  <= 1'b1;
        end
        // Accept overrides the end-of-word clear above.
        if (accept) begin
          word_buf  <= s_dma_data;
          buf_valid <= 1'b1;
          idx       <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_dac_jesd204_upack.sv
module tb_axi_dac_jesd204_upack;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   en;
  logic         valid;
  logic [127:0] data;
  logic         ready;
  logic [127:0] out;
  logic         ovalid, dunf;
  logic [3:0]   en4;
  logic [255:0] data4;
  logic         ready4;
  logic [255:0] out4;
  logic         ovalid4, dunf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_dac_jesd204_upack #(.NUM_CHANNELS(2), .DATA_PATH_WIDTH(4), .OCT_PER_SAMPLE(2)) dut (
    .dac_clk(clk), .dac_rst(rst), .dac_enable(en), .s_dma_valid(valid),
    .s_dma_ready(ready), .s_dma_data(data), .dac_data(out),
    .dac_valid(ovalid), .dac_dunf(dunf));

  axi_dac_jesd204_upack #(.NUM_CHANNELS(4), .DATA_PATH_WIDTH(4), .OCT_PER_SAMPLE(2)) dut4 (
    .dac_clk(clk), .dac_rst(rst), .dac_enable(en4), .s_dma_valid(valid),
    .s_dma_ready(ready4), .s_dma_data(data4), .dac_data(out4),
    .dac_valid(ovalid4), .dac_dunf(dunf4));

  // Word whose slot k holds b+k.
  function automatic logic [127:0] mk2(input logic [15:0] b);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = b + 16'(k);
    return w;
  endfunction

  function automatic logic [255:0] mk4(input logic [15:0] b);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = b + 16'(k);
    return w;
  endfunction

  // Both channels: ch0 gets even slots, ch1 odd slots.
  function automatic logic [127:0] exp_both(input logic [15:0] b);
    return {b+16'd7, b+16'd5, b+16'd3, b+16'd1, b+16'd6, b+16'd4, b+16'd2, b};
  endfunction

  // Only ch1: consecutive slots, half h selects slots 0..3 or 4..7.
  function automatic logic [127:0] exp_single(input logic [15:0] b, input int h);
    logic [15:0] o;
    o = b + ((h != 0) ? 16'd4 : 16'd0);
    return {o+16'd3, o+16'd2, o+16'd1, o, 64'h0};
  endfunction

  // 4-ch DUT with ch0 and ch2 enabled: ch0 even, ch2 odd; half 1 starts at slot 8.
  function automatic logic [255:0] exp_quad(input logic [15:0] b, input int h);
    logic [15:0] o;
    o = b + ((h != 0) ? 16'd8 : 16'd0);
    return {64'h0, o+16'd7, o+16'd5, o+16'd3, o+16'd1,
            64'h0, o+16'd6, o+16'd4, o+16'd2, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (out !== 128'h0 || ovalid !== 1'b0 || dunf !== 1'b0) begin errors++;
      $display("FAIL reset_out: got data=%h v=%b u=%b, want 0/0/0", out, ovalid, dunf); end
    checks++; if (ready !== 1'b0 || ready4 !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b/%b, want 0/0", ready, ready4); end
    rst = 1'b0;
  endtask

  task automatic test_both();
    #1;
    checks++; if (ready !== 1'b0) begin errors++;
      $display("FAIL both_chg_ready: got %b want 0", ready); end
    tick();
    checks++; if (out !== 128'h0 || dunf !== 1'b0) begin errors++;
      $display("FAIL both_chg_out: got data=%h u=%b, want 0/0", out, dunf); end
    data = mk2(16'h0000);
    #1;
    checks++; if (ready !== 1'b1) begin errors++;
      $display("FAIL both_first_ready: got %b want 1", ready); end
    tick();
    checks++; if (dunf !== 1'b1 || ovalid !== 1'b0 || out !== 128'h0) begin errors++;
      $display("FAIL both_leadin: got u=%b v=%b data=%h, want 1/0/0", dunf, ovalid, out); end
    for (int n = 1; n <= 3; n++) begin
      data = mk2(16'(n << 8));
      #1;
      checks++; if (ready !== 1'b1) begin errors++;
        $display("FAIL both_ready%0d: got %b want 1", n, ready); end
      tick();
      checks++; if (out !== exp_both(16'((n-1) << 8)) || ovalid !== 1'b1 || dunf !== 1'b0) begin errors++;
        $display("FAIL both_word%0d: got %h v=%b u=%b, want %h v=1 u=0", n-1, out, ovalid, dunf, exp_both(16'((n-1) << 8))); end
    end
  endtask

  task automatic test_underflow();
    valid = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++;
      $display("FAIL unf_ready: got %b want 1", ready); end
    tick();
    checks++; if (out !== exp_both(16'h0300) || ovalid !== 1'b1) begin errors++;
      $display("FAIL unf_last: got %h v=%b, want %h v=1", out, ovalid, exp_both(16'h0300)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (dunf !== 1'b1 || ovalid !== 1'b0 || out !== 128'h0) begin errors++;
        $display("FAIL unf_gap%0d: got u=%b v=%b data=%h, want 1/0/0", i, dunf, ovalid, out); end
    end
    valid = 1'b1;
    data  = mk2(16'h0400);
    tick();
    checks++; if (dunf !== 1'b1 || ovalid !== 1'b0 || out !== 128'h0) begin errors++;
      $display("FAIL unf_gap2: got u=%b v=%b data=%h, want 1/0/0", dunf, ovalid, out); end
    data = mk2(16'h0500);
    tick();
    checks++; if (out !== exp_both(16'h0400) || ovalid !== 1'b1 || dunf !== 1'b0) begin errors++;
      $display("FAIL unf_resume: got %h v=%b u=%b, want %h v=1 u=0", out, ovalid, dunf, exp_both(16'h0400)); end
  endtask

  task automatic test_single();
    en   = 2'b10;
    data = mk2(16'h1000);
    #1;
    checks++; if (ready !== 1'b0) begin errors++;
      $display("FAIL single_chg_ready: got %b want 0", ready); end
    tick();
    checks++; if (out !== 128'h0 || dunf !== 1'b0 || ovalid !== 1'b0) begin errors++;
      $display("FAIL single_chg_out: got %h u=%b v=%b, want 0/0/0", out, dunf, ovalid); end
    checks++; if (ready !== 1'b1) begin errors++;
      $display("FAIL single_load_ready: got %b want 1", ready); end
    tick();
    checks++; if (dunf !== 1'b1) begin errors++;
      $display("FAIL single_leadin: got u=%b want 1", dunf); end
    checks++; if (ready !== 1'b0) begin errors++;
      $display("FAIL single_idx0_ready: got %b want 0", ready); end
    tick();
    checks++; if (out !== exp_single(16'h1000, 0) || ovalid !== 1'b1) begin errors++;
      $display("FAIL single_half0: got %h v=%b, want %h", out, ovalid, exp_single(16'h1000, 0)); end
    checks++; if (ready !== 1'b1) begin errors++;
      $display("FAIL single_idx1_ready: got %b want 1", ready); end
    data = mk2(16'h1100);
    tick();
    checks++; if (out !== exp_single(16'h1000, 1) || ovalid !== 1'b1) begin errors++;
      $display("FAIL single_half1: got %h v=%b, want %h", out, ovalid, exp_single(16'h1000, 1)); end
    checks++; if (ready !== 1'b0) begin errors++;
      $display("FAIL single_next_ready: got %b want 0", ready); end
    tick();
    checks++; if (out !== exp_single(16'h1100, 0)) begin errors++;
      $display("FAIL single_next_half0: got %h want %h", out, exp_single(16'h1100, 0)); end
  endtask

  task automatic test_enable_change();
    en   = 2'b11;
    data = mk2(16'h1200);
    #1;
    checks++; if (ready !== 1'b0) begin errors++;
      $display("FAIL chg_ready: got %b want 0", ready); end
    tick();
    checks++; if (out !== 128'h0 || dunf !== 1'b0 || ovalid !== 1'b0) begin errors++;
      $display("FAIL chg_out: got %h u=%b v=%b, want 0/0/0", out, dunf, ovalid); end
    checks++; if (ready !== 1'b1) begin errors++;
      $display("FAIL chg_load_ready: got %b want 1", ready); end
    tick();
    checks++; if (dunf !== 1'b1 || out !== 128'h0) begin errors++;
      $display("FAIL chg_flushed: got u=%b data=%h, want 1/0", dunf, out); end
    data = mk2(16'h1300);
    tick();
    checks++; if (out !== exp_both(16'h1200)) begin errors++;
      $display("FAIL chg_newmap: got %h want %h", out, exp_both(16'h1200)); end
  endtask

  task automatic test_reset_mid();
    en   = 2'b10;
    data = mk2(16'h2000);
    tick();
    tick();
    tick();
    checks++; if (out !== exp_single(16'h2000, 0)) begin errors++;
      $display("FAIL rstmid_pre: got %h want %h", out, exp_single(16'h2000, 0)); end
    rst = 1'b1;
    tick();
    checks++; if (out !== 128'h0 || ovalid !== 1'b0 || dunf !== 1'b0 || ready !== 1'b0) begin errors++;
      $display("FAIL rstmid_out: got %h v=%b u=%b r=%b, want 0", out, ovalid, dunf, ready); end
    rst  = 1'b0;
    data = mk2(16'h2100);
    tick();
    checks++; if (out !== 128'h0 || dunf !== 1'b0) begin errors++;
      $display("FAIL rstmid_chg: got %h u=%b, want 0/0", out, dunf); end
    tick();
    checks++; if (dunf !== 1'b1) begin errors++;
      $display("FAIL rstmid_leadin: got u=%b want 1", dunf); end
    tick();
    checks++; if (out !== exp_single(16'h2100, 0)) begin errors++;
      $display("FAIL rstmid_half0: got %h want %h", out, exp_single(16'h2100, 0)); end
    tick();
    checks++; if (out !== exp_single(16'h2100, 1)) begin errors++;
      $display("FAIL rstmid_half1: got %h want %h", out, exp_single(16'h2100, 1)); end
  endtask

  task automatic test_idle();
    en = 2'b00;
    tick();
    tick();
    checks++; if (ready !== 1'b0 || out !== 128'h0 || dunf !== 1'b0 || ovalid !== 1'b0) begin errors++;
      $display("FAIL idle_none: got r=%b data=%h u=%b v=%b, want 0", ready, out, dunf, ovalid); end
    en4 = 4'b0111;
    data4 = mk4(16'h3000);
    tick();
    tick();
    checks++; if (ready4 !== 1'b0 || out4 !== 256'h0 || dunf4 !== 1'b0 || ovalid4 !== 1'b0) begin errors++;
      $display("FAIL idle_three: got r=%b data=%h u=%b v=%b, want 0", ready4, out4, dunf4, ovalid4); end
  endtask

  task automatic test_quad();
    en4   = 4'b0101;
    data4 = mk4(16'h4000);
    tick();
    checks++; if (ready4 !== 1'b1) begin errors++;
      $display("FAIL quad_ready: got %b want 1", ready4); end
    tick();
    checks++; if (dunf4 !== 1'b1) begin errors++;
      $display("FAIL quad_leadin: got u=%b want 1", dunf4); end
    tick();
    checks++; if (out4 !== exp_quad(16'h4000, 0) || ovalid4 !== 1'b1) begin errors++;
      $display("FAIL quad_half0: got %h want %h", out4, exp_quad(16'h4000, 0)); end
    tick();
    checks++; if (out4 !== exp_quad(16'h4000, 1) || ovalid4 !== 1'b1) begin errors++;
      $display("FAIL quad_half1: got %h want %h", out4, exp_quad(16'h4000, 1)); end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 2'b11;
    valid = 1'b1;
    data  = mk2(16'h0000);
    en4   = 4'b0000;
    data4 = '0;
    test_reset();
    test_both();
    test_underflow();
    test_single();
    test_enable_change();
    test_reset_mid();
    test_idle();
    test_quad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
